// File: rtl/calc_pkg.sv
// Shared encodings for the calculator sequencer: key codes, ALU opcodes,
// error codes and the sequencer state enumeration.
package calc_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_DIV = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_CLR = 4'd15;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MUL = 2'b10,
        ALU_DIV = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_OVF  = 2'b01,
        ERR_DZ   = 2'b10,
        ERR_TMO  = 2'b11
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPA,
        ST_OPB,
        ST_EXEC,
        ST_WAIT,
        ST_SHOW,
        ST_ERR
    } state_e;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_operator(input logic [3:0] k);
        return (k >= KEY_ADD) && (k <= KEY_DIV);
    endfunction

    // Operator keys are not contiguous with the opcode bits, so map explicitly.
    function automatic alu_op_e key_to_op(input logic [3:0] k);
        alu_op_e op;
        case (k)
            KEY_SUB: op = ALU_SUB;
            KEY_MUL: op = ALU_MUL;
            KEY_DIV: op = ALU_DIV;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/calc_dec_acc.sv
// Decimal digit accumulator: acc*10 + digit with saturation at the 16-bit
// maximum. Purely combinational; the caller owns the register.
module calc_dec_acc
    import calc_pkg::*;
(
    input  logic [DATA_W-1:0] acc_in,
    input  logic              restart,
    input  logic [3:0]        digit,
    output logic [DATA_W-1:0] acc_out,
    output logic              sat
);

    // Four guard bits hold 65535*10+9 without wrap.
    logic [DATA_W+3:0] base;
    logic [DATA_W+3:0] sum;

    always_comb begin
        base    = restart ? '0 : {4'd0, acc_in};
        sum     = (base << 3) + (base << 1) + {{DATA_W{1'b0}}, digit};
        sat     = |sum[DATA_W+3:DATA_W];
        acc_out = sat ? '1 : sum[DATA_W-1:0];
    end

endmodule

// File: rtl/calc_sequencer.sv
// Keypad-driven calculator sequencer: accumulates two decimal operands,
// issues one ALU request per equals key and tracks ALU errors and timeouts.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    output logic              alu_start,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_ovf,
    input  logic              alu_dz,
    output logic [DATA_W-1:0] disp_value,
    output logic              busy,
    output logic [1:0]        err_code
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] acc_a_q, acc_a_d;
    logic [DATA_W-1:0] acc_b_q, acc_b_d;
    logic [DATA_W-1:0] disp_q, disp_d;
    alu_op_e           op_q, op_d;
    err_e              err_q, err_d;
    logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;

    logic [DATA_W-1:0] acc_a_dig, acc_b_dig;
    logic              acc_a_sat, acc_b_sat;
    logic              key_clr, key_dig, key_op, key_eq;

    assign key_clr = key_valid && (key_code == KEY_CLR);
    assign key_dig = key_valid && is_digit(key_code);
    assign key_op  = key_valid && is_operator(key_code);
    assign key_eq  = key_valid && (key_code == KEY_EQ);

    // A digit after a finished result (or from idle) starts a fresh operand.
    calc_dec_acc u_acc_a (
        .acc_in  (acc_a_q),
        .restart ((state_q == ST_IDLE) || (state_q == ST_SHOW)),
        .digit   (key_code),
        .acc_out (acc_a_dig),
        .sat     (acc_a_sat)
    );

    calc_dec_acc u_acc_b (
        .acc_in  (acc_b_q),
        .restart (1'b0),
        .digit   (key_code),
        .acc_out (acc_b_dig),
        .sat     (acc_b_sat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            acc_a_q   <= '0;
            acc_b_q   <= '0;
            disp_q    <= '0;
            op_q      <= ALU_ADD;
            err_q     <= ERR_NONE;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_a_q   <= acc_a_d;
            acc_b_q   <= acc_b_d;
            disp_q    <= disp_d;
            op_q      <= op_d;
            err_q     <= err_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_a_d   = acc_a_q;
        acc_b_d   = acc_b_q;
        disp_d    = disp_q;
        op_d      = op_q;
        err_d     = err_q;
        tmo_cnt_d = tmo_cnt_q;

        if (key_clr) begin
            state_d   = ST_IDLE;
            acc_a_d   = '0;
            acc_b_d   = '0;
            disp_d    = '0;
            err_d     = ERR_NONE;
            tmo_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_OPA, ST_SHOW: begin
                    if (key_dig) begin
                        acc_a_d = acc_a_dig;
                        disp_d  = acc_a_dig;
                        state_d = acc_a_sat ? ST_ERR : ST_OPA;
                        if (acc_a_sat) err_d = ERR_OVF;
                    end else if (key_op && (state_q != ST_IDLE)) begin
                        op_d    = key_to_op(key_code);
                        acc_b_d = '0;
                        state_d = ST_OPB;
                    end
                end
                ST_OPB: begin
                    if (key_dig) begin
                        acc_b_d = acc_b_dig;
                        disp_d  = acc_b_dig;
                        if (acc_b_sat) begin
                            state_d = ST_ERR;
                            err_d   = ERR_OVF;
                        end
                    end else if (key_op) begin
                        op_d = key_to_op(key_code);
                    end else if (key_eq) begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state_d   = ST_WAIT;
                    tmo_cnt_d = '0;
                end
                ST_WAIT: begin
                    // Completion on the last counted cycle takes priority over timeout.
                    if (alu_done) begin
                        if (alu_dz) begin
                            state_d = ST_ERR;
                            err_d   = ERR_DZ;
                        end else if (alu_ovf) begin
                            state_d = ST_ERR;
                            err_d   = ERR_OVF;
                        end else begin
                            acc_a_d = alu_result;
                            disp_d  = alu_result;
                            state_d = ST_SHOW;
                        end
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        state_d = ST_ERR;
                        err_d   = ERR_TMO;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                    end
                end
                ST_ERR:  state_d = ST_ERR;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        alu_start  = (state_q == ST_EXEC);
        busy       = (state_q == ST_EXEC) || (state_q == ST_WAIT);
        alu_op     = op_q;
        alu_a      = acc_a_q;
        alu_b      = acc_b_q;
        disp_value = disp_q;
        err_code   = err_q;
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: stimulus queues expected ALU requests
// and output snapshots; a negedge monitor pops and compares them.
module tb_calc_sequencer;

    localparam int T = 16;

    localparam logic [3:0] K_ADD = 4'd10;
    localparam logic [3:0] K_SUB = 4'd11;
    localparam logic [3:0] K_MUL = 4'd12;
    localparam logic [3:0] K_DIV = 4'd13;
    localparam logic [3:0] K_EQ  = 4'd14;
    localparam logic [3:0] K_CLR = 4'd15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        alu_start;
    logic [1:0]  alu_op;
    logic [15:0] alu_a, alu_b;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = 16'd0;
    logic        alu_ovf = 1'b0;
    logic        alu_dz = 1'b0;
    logic [15:0] disp_value;
    logic        busy;
    logic [1:0]  err_code;

    calc_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_ovf    (alu_ovf),
        .alu_dz     (alu_dz),
        .disp_value (disp_value),
        .busy       (busy),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
    } start_t;

    typedef struct {
        string       name;
        logic [15:0] disp;
        logic [1:0]  err;
        logic        busy;
        logic [15:0] a;
        logic [15:0] b;
    } snap_t;

    start_t q_start[$];
    snap_t  q_snap[$];
    start_t es;
    snap_t  ss;
    int     tests = 0;
    int     fails = 0;
    logic   probe = 1'b0;

    // Monitor: every alu_start pulse and every probe strobe consumes one entry.
    always @(negedge clk) begin
        if (alu_start) begin
            tests++;
            if (q_start.size() == 0) begin
                fails++;
                $display("FAIL start_unexpected: got alu_start a=%0d b=%0d op=%0d, required no request",
                         alu_a, alu_b, alu_op);
            end else begin
                es = q_start.pop_front();
                if (alu_a !== es.a || alu_b !== es.b || alu_op !== es.op) begin
                    fails++;
                    $display("FAIL start_operands: got a=%0d b=%0d op=%0d, required a=%0d b=%0d op=%0d",
                             alu_a, alu_b, alu_op, es.a, es.b, es.op);
                end else begin
                    $display("[TB] alu_start a=%0d b=%0d op=%0d ok", alu_a, alu_b, alu_op);
                end
            end
        end
        if (probe) begin
            tests++;
            ss = q_snap.pop_front();
            if (disp_value !== ss.disp || err_code !== ss.err || busy !== ss.busy ||
                alu_a !== ss.a || alu_b !== ss.b) begin
                fails++;
                $display("FAIL %s: got disp=%0d err=%0d busy=%0d a=%0d b=%0d, required disp=%0d err=%0d busy=%0d a=%0d b=%0d",
                         ss.name, disp_value, err_code, busy, alu_a, alu_b,
                         ss.disp, ss.err, ss.busy, ss.a, ss.b);
            end else begin
                $display("[TB] check %s ok", ss.name);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_code  = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic check(input string name, input logic [15:0] disp, input logic [1:0] err,
                         input logic bsy, input logic [15:0] a, input logic [15:0] b);
        q_snap.push_back('{name, disp, err, bsy, a, b});
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    task automatic expect_start(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        q_start.push_back('{a, b, op});
    endtask

    task automatic wait_start();
        int n = 0;
        while (!alu_start && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (!alu_start) begin
            fails++;
            $display("FAIL wait_start: got no alu_start within 20 cycles, required a request");
        end
    endtask

    // ALU model: completes in the given WAIT cycle (1 = first WAIT cycle).
    task automatic respond(input int cycles, input logic [15:0] res, input logic ovf, input logic dz);
        wait_start();
        tick();
        repeat (cycles - 1) tick();
        alu_result = res;
        alu_ovf    = ovf;
        alu_dz     = dz;
        alu_done   = 1'b1;
        tick();
        alu_done   = 1'b0;
        alu_ovf    = 1'b0;
        alu_dz     = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        check("reset_held", 16'd0, 2'd0, 1'b0, 16'd0, 16'd0);
        rst = 1'b1;
        tick();
        check("reset_released", 16'd0, 2'd0, 1'b0, 16'd0, 16'd0);

        // 12 + 34 = 46, ALU answers in the third WAIT cycle
        press(4'd1); press(4'd2);
        check("s1_opa", 16'd12, 2'd0, 1'b0, 16'd12, 16'd0);
        press(K_ADD); press(4'd3); press(4'd4);
        check("s1_opb", 16'd34, 2'd0, 1'b0, 16'd12, 16'd34);
        expect_start(16'd12, 16'd34, 2'b00);
        press(K_EQ);
        respond(3, 16'd46, 1'b0, 1'b0);
        check("s1_result", 16'd46, 2'd0, 1'b0, 16'd46, 16'd34);
        press(K_CLR);

        // 9 / 0 -> divide-by-zero, then clear
        press(4'd9); press(K_DIV); press(4'd0);
        expect_start(16'd9, 16'd0, 2'b11);
        press(K_EQ);
        respond(2, 16'd0, 1'b0, 1'b1);
        check("s2_dz", 16'd0, 2'd2, 1'b0, 16'd9, 16'd0);
        press(K_CLR);
        check("s2_clear", 16'd0, 2'd0, 1'b0, 16'd0, 16'd0);

        // 65536 saturates, ERR ignores further keys
        press(4'd6); press(4'd5); press(4'd5); press(4'd3);
        check("s3_6553", 16'd6553, 2'd0, 1'b0, 16'd6553, 16'd0);
        press(4'd6);
        check("s3_sat", 16'd65535, 2'd1, 1'b0, 16'd65535, 16'd0);
        press(4'd4); press(K_EQ);
        check("s3_err_hold", 16'd65535, 2'd1, 1'b0, 16'd65535, 16'd0);
        press(K_CLR);
        check("s3_clear", 16'd0, 2'd0, 1'b0, 16'd0, 16'd0);

        // 5 * 5 with no alu_done -> timeout exactly T cycles after WAIT entry
        press(4'd5); press(K_MUL); press(4'd5);
        expect_start(16'd5, 16'd5, 2'b10);
        press(K_EQ);
        wait_start();
        tick();
        repeat (T - 1) tick();
        check("s4_wait_last", 16'd5, 2'd0, 1'b1, 16'd5, 16'd5);
        check("s4_timeout", 16'd5, 2'd3, 1'b0, 16'd5, 16'd5);
        press(K_CLR);

        // chain: 2 + 3 = 5, then * 4 = 20
        press(4'd2); press(K_ADD); press(4'd3);
        expect_start(16'd2, 16'd3, 2'b00);
        press(K_EQ);
        respond(2, 16'd5, 1'b0, 1'b0);
        check("s5_first", 16'd5, 2'd0, 1'b0, 16'd5, 16'd3);
        press(K_MUL); press(4'd4);
        check("s5_chain_opb", 16'd4, 2'd0, 1'b0, 16'd5, 16'd4);
        expect_start(16'd5, 16'd4, 2'b10);
        press(K_EQ);
        respond(1, 16'd20, 1'b0, 1'b0);
        check("s5_second", 16'd20, 2'd0, 1'b0, 16'd20, 16'd4);
        press(K_CLR);

        // operator replacement in OPB: 8 + - 2 -> subtract
        press(4'd8); press(K_ADD); press(K_SUB); press(4'd2);
        expect_start(16'd8, 16'd2, 2'b01);
        press(K_EQ);
        respond(1, 16'd6, 1'b0, 1'b0);
        check("s6_sub", 16'd6, 2'd0, 1'b0, 16'd6, 16'd2);
        press(4'd7);
        check("s6_digit_after_show", 16'd7, 2'd0, 1'b0, 16'd7, 16'd2);
        press(K_CLR);

        // ALU overflow flag
        press(4'd9); press(4'd9); press(K_MUL); press(4'd9);
        expect_start(16'd99, 16'd9, 2'b10);
        press(K_EQ);
        respond(4, 16'd0, 1'b1, 1'b0);
        check("s7_alu_ovf", 16'd9, 2'd1, 1'b0, 16'd99, 16'd9);
        press(K_CLR);

        // clear during WAIT, late alu_done ignored
        press(4'd3); press(K_ADD); press(4'd4);
        expect_start(16'd3, 16'd4, 2'b00);
        press(K_EQ);
        wait_start();
        tick();
        press(K_CLR);
        alu_result = 16'd7;
        alu_done   = 1'b1;
        tick();
        alu_done   = 1'b0;
        check("s8_late_done", 16'd0, 2'd0, 1'b0, 16'd0, 16'd0);

        // reset asserted mid-WAIT
        press(4'd6); press(K_SUB); press(4'd1);
        expect_start(16'd6, 16'd1, 2'b01);
        press(K_EQ);
        wait_start();
        tick();
        rst = 1'b0;
        check("s9_rst_mid_wait", 16'd0, 2'd0, 1'b0, 16'd0, 16'd0);
        alu_result = 16'd5;
        alu_done   = 1'b1;
        tick();
        alu_done   = 1'b0;
        rst = 1'b1;
        tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("s9_after_reset", 16'd0, 2'd0, 1'b0, 16'd0, 16'd0);
        press(4'd2);
        check("s9_digit", 16'd2, 2'd0, 1'b0, 16'd2, 16'd0);

        tick();
        tests++;
        if (q_start.size() != 0) begin
            fails++;
            $display("FAIL start_queue: got %0d requests never issued, required 0", q_start.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
